// File: rtl/alu_control_seq.sv
// alu_control_seq: ALU-select decoder for the multicycle MIPS core plus an
// iterative mult/multu/div/divu sequencer with architectural Hi/Lo registers.
// A mult/div takes W iteration cycles plus one sign-fix cycle. A divide by
// zero completes straight away and leaves Hi/Lo unchanged.
module alu_control_seq #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [1:0]   i_alu_op,
    input  logic [5:0]   i_funct,
    input  logic         i_start,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [2:0]   o_alu_sel,
    output logic         o_break,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_div_zero,
    output logic [W-1:0] o_hi,
    output logic [W-1:0] o_lo
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [2*W-1:0]  r_acc;      // mult: {partial hi, multiplier}; div: {remainder, dividend/quotient}
    logic [W-1:0]    r_opnd;     // multiplicand magnitude or divisor magnitude
    logic            r_is_div;
    logic            r_neg_res;  // product / quotient must be negated
    logic            r_neg_rem;  // remainder must be negated (dividend was negative)
    logic            r_div_zero;
    logic [W-1:0]    r_hi;
    logic [W-1:0]    r_lo;

    // Acceptance and operand-conditioning wires
    logic            w_seq_op;
    logic            w_idle_like;
    logic            w_accept;
    logic            w_is_div;
    logic            w_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [W-1:0]    w_a_mag;
    logic [W-1:0]    w_b_mag;
    logic            w_b_zero;

    // Iteration and sign-fix wires
    logic [W:0]      w_mul_sum;
    logic [2*W-1:0]  w_mul_step;
    logic [W:0]      w_div_shift;
    logic [W:0]      w_div_diff;
    logic            w_div_ge;
    logic [2*W-1:0]  w_div_step;
    logic [2*W-1:0]  w_prod;
    logic [W-1:0]    w_quot;
    logic [W-1:0]    w_rem;
    logic [W-1:0]    w_fix_hi;
    logic [W-1:0]    w_fix_lo;

    // Combinational ALU-select decode, independent of the sequencer
    always_comb begin
        o_alu_sel = 3'b001;
        case (i_alu_op)
            2'b01: o_alu_sel = 3'b010;
            2'b11: o_alu_sel = 3'b011;
            2'b10: begin
                case (i_funct)
                    6'h20, 6'h21: o_alu_sel = 3'b001;
                    6'h22, 6'h23: o_alu_sel = 3'b010;
                    6'h24:        o_alu_sel = 3'b011;
                    6'h26:        o_alu_sel = 3'b110;
                    6'h2a:        o_alu_sel = 3'b111;
                    default:      o_alu_sel = 3'b001;
                endcase
            end
            default: o_alu_sel = 3'b001;
        endcase
    end

    assign o_break = (i_alu_op == 2'b10) && (i_funct == 6'h0d);

    // 0x18..0x1b share funct[5:2]; funct[1] picks divide, funct[0] picks unsigned
    assign w_seq_op    = (i_funct[5:2] == 4'b0110);
    assign w_idle_like = (r_state == IDLE) || (r_state == DONE);
    assign w_accept    = i_start && w_idle_like && (i_alu_op == 2'b10) && w_seq_op;
    assign w_is_div    = i_funct[1];
    assign w_signed    = ~i_funct[0];
    assign w_a_neg     = w_signed & i_a[W-1];
    assign w_b_neg     = w_signed & i_b[W-1];
    assign w_a_mag     = w_a_neg ? (~i_a + 1'b1) : i_a;
    assign w_b_mag     = w_b_neg ? (~i_b + 1'b1) : i_b;
    assign w_b_zero    = (i_b == '0);

    // Shift-add: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});
    assign w_mul_step = {w_mul_sum, r_acc[W-1:1]};

    // Restoring divide: shift next dividend bit into the remainder and
    // subtract the divisor if it fits; quotient bits enter at the bottom.
    assign w_div_shift = r_acc[2*W-1:W-1];
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_div_step  = w_div_ge ? {w_div_diff[W-1:0], r_acc[W-2:0], 1'b1}
                                  : {w_div_shift[W-1:0], r_acc[W-2:0], 1'b0};

    // Sign correction applied in FIX
    assign w_prod   = r_neg_res ? (~r_acc + 1'b1) : r_acc;
    assign w_quot   = r_neg_res ? (~r_acc[W-1:0] + 1'b1) : r_acc[W-1:0];
    assign w_rem    = r_neg_rem ? (~r_acc[2*W-1:W] + 1'b1) : r_acc[2*W-1:W];
    assign w_fix_hi = r_is_div ? w_rem  : w_prod[2*W-1:W];
    assign w_fix_lo = r_is_div ? w_quot : w_prod[W-1:0];

    // Next-state logic for the sequencer
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_accept) begin
                    if (!w_is_div)     w_state_next = MUL;
                    else if (w_b_zero) w_state_next = DONE;
                    else               w_state_next = DIV;
                end else begin
                    w_state_next = IDLE;
                end
            end
            MUL, DIV: begin
                if (r_cnt == LAST_ITER) w_state_next = FIX;
            end
            FIX:     w_state_next = DONE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    // Operand capture, iteration datapath and Hi/Lo write-back
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else if (w_accept) begin
            r_cnt      <= '0;
            r_is_div   <= w_is_div;
            r_neg_res  <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= w_a_neg;
            r_div_zero <= w_is_div & w_b_zero;
            if (w_is_div) begin
                r_acc  <= {{W{1'b0}}, w_a_mag};
                r_opnd <= w_b_mag;
            end else begin
                r_acc  <= {{W{1'b0}}, w_b_mag};
                r_opnd <= w_a_mag;
            end
        end else begin
            case (r_state)
                MUL: begin
                    r_acc <= w_mul_step;
                    r_cnt <= r_cnt + CW'(1);
                end
                DIV: begin
                    r_acc <= w_div_step;
                    r_cnt <= r_cnt + CW'(1);
                end
                FIX: begin
                    r_hi <= w_fix_hi;
                    r_lo <= w_fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign o_busy     = (r_state == MUL) || (r_state == DIV) || (r_state == FIX);
    assign o_done     = (r_state == DONE);
    assign o_div_zero = o_done & r_div_zero;
    assign o_hi       = r_hi;
    assign o_lo       = r_lo;

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq (W=32): decode vector table,
// directed multi-cycle sequences and randomized mult/div against a model.
module tb_alu_control_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  alu_sel;
    logic        brk;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    logic [31:0] mdl_hi = 32'd0;
    logic [31:0] mdl_lo = 32'd0;

    alu_control_seq #(.W(32)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_alu_op   (alu_op),
        .i_funct    (funct),
        .i_start    (start),
        .i_a        (a),
        .i_b        (b),
        .o_alu_sel  (alu_sel),
        .o_break    (brk),
        .o_busy     (busy),
        .o_done     (done),
        .o_div_zero (dz),
        .o_hi       (hi),
        .o_lo       (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [5:0] fn;
        logic [2:0] sel;
        logic       brk;
    } dec_vec_t;

    dec_vec_t dtab[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Decode reference taken directly from the opcode table
    function automatic logic [2:0] ref_sel(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'b00) return 3'b001;
        if (op == 2'b01) return 3'b010;
        if (op == 2'b11) return 3'b011;
        if (fn == 6'h20 || fn == 6'h21) return 3'b001;
        if (fn == 6'h22 || fn == 6'h23) return 3'b010;
        if (fn == 6'h24) return 3'b011;
        if (fn == 6'h26) return 3'b110;
        if (fn == 6'h2a) return 3'b111;
        return 3'b001;
    endfunction

    // Arithmetic reference using native 64-bit math
    function automatic void ref_op(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                                   input logic [31:0] hi0, input logic [31:0] lo0,
                                   output logic [31:0] eh, output logic [31:0] el, output logic ed);
        longint sa, sb, q, r;
        logic [63:0] p;
        eh = hi0; el = lo0; ed = 1'b0;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        case (f)
            6'h18: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
            6'h19: begin p = {32'd0, av} * {32'd0, bv}; eh = p[63:32]; el = p[31:0]; end
            6'h1a: begin
                if (bv == 32'd0) ed = 1'b1;
                else begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; end
            end
            default: begin
                if (bv == 32'd0) ed = 1'b1;
                else begin el = av / bv; eh = av % bv; end
            end
        endcase
    endfunction

    // Drive a Start for one edge (E); returns at the negedge right after E
    task automatic start_op(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        alu_op = 2'b10; funct = f; a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for Done; lat counts edges after E
    task automatic wait_done(input int exp_lat, input int lat0, input logic exp_dz, input string nm);
        int lat = lat0;
        logic busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, " busy_while_running"}, 64'(busy_ok), 64'd1);
        chk({nm, " busy_at_done"}, 64'(busy), 64'd0);
        chk({nm, " divzero"}, 64'(dz), 64'(exp_dz));
    endtask

    task automatic run_op(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] eh, input logic [31:0] el, input logic ed, input string nm);
        start_op(f, av, bv);
        wait_done(ed ? 0 : 33, 0, ed, nm);
        chk({nm, " hi"}, 64'(hi), 64'(eh));
        chk({nm, " lo"}, 64'(lo), 64'(el));
        $display("op %s funct=%02h a=%08h b=%08h -> hi=%08h lo=%08h dz=%0d", nm, f, av, bv, hi, lo, dz);
        @(negedge clk);
        chk({nm, " done_pulse"}, 64'(done), 64'd0);
        mdl_hi = eh;
        mdl_lo = el;
    endtask

    initial begin
        logic [31:0] eh, el, av, bv;
        logic        ed, seen;
        logic [5:0]  f;
        logic [1:0]  rop;
        int          lat;

        dtab[0]  = '{2'b10, 6'h20, 3'b001, 1'b0};
        dtab[1]  = '{2'b10, 6'h21, 3'b001, 1'b0};
        dtab[2]  = '{2'b10, 6'h22, 3'b010, 1'b0};
        dtab[3]  = '{2'b10, 6'h23, 3'b010, 1'b0};
        dtab[4]  = '{2'b10, 6'h24, 3'b011, 1'b0};
        dtab[5]  = '{2'b10, 6'h26, 3'b110, 1'b0};
        dtab[6]  = '{2'b10, 6'h2a, 3'b111, 1'b0};
        dtab[7]  = '{2'b10, 6'h0d, 3'b001, 1'b1};
        dtab[8]  = '{2'b00, 6'h0d, 3'b001, 1'b0};
        dtab[9]  = '{2'b01, 6'h2a, 3'b010, 1'b0};
        dtab[10] = '{2'b01, 6'h0d, 3'b010, 1'b0};
        dtab[11] = '{2'b11, 6'h20, 3'b011, 1'b0};
        dtab[12] = '{2'b10, 6'h18, 3'b001, 1'b0};
        dtab[13] = '{2'b10, 6'h3f, 3'b001, 1'b0};

        rst_n = 1'b1; alu_op = 2'b00; funct = 6'h00; start = 1'b0; a = 32'd0; b = 32'd0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset divzero", 64'(dz), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);

        // Decode table
        for (int i = 0; i < 14; i++) begin
            alu_op = dtab[i].op; funct = dtab[i].fn;
            #1;
            chk($sformatf("dec%0d sel", i), 64'(alu_sel), 64'(dtab[i].sel));
            chk($sformatf("dec%0d brk", i), 64'(brk), 64'(dtab[i].brk));
            $display("dec op=%b funct=%02h -> sel=%b break=%b", dtab[i].op, dtab[i].fn, alu_sel, brk);
        end

        // Random decode
        for (int i = 0; i < 20; i++) begin
            rop = 2'($urandom_range(0, 3));
            f = 6'($urandom);
            alu_op = rop; funct = f;
            #1;
            chk("rdec sel", 64'(alu_sel), 64'(ref_sel(rop, f)));
            chk("rdec brk", 64'(brk), 64'((rop == 2'b10) && (f == 6'h0d)));
            $display("rdec op=%b funct=%02h -> sel=%b break=%b", rop, f, alu_sel, brk);
        end

        // Start with a non-sequenced opcode is ignored
        @(negedge clk);
        alu_op = 2'b00; funct = 6'h18; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("nonseq start busy", 64'(busy), 64'd0);
        chk("nonseq start done", 64'(done), 64'd0);

        // Directed arithmetic cases
        run_op(6'h18, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "mult");
        run_op(6'h19, 32'hFFFFFFFF, 32'd3, 32'h00000002, 32'hFFFFFFFD, 1'b0, "multu");
        run_op(6'h1a, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div");
        run_op(6'h1b, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, "divu");
        run_op(6'h1a, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, "div_ovf");

        // Divide by zero leaves Hi/Lo alone
        run_op(6'h1b, 32'h451, 32'h20, 32'h11, 32'h22, 1'b0, "divu_setup");
        run_op(6'h1a, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, "div_zero");

        // Re-pulsed Start while busy is ignored
        start_op(6'h19, 32'd2, 32'd3);
        repeat (4) @(negedge clk);
        alu_op = 2'b10; funct = 6'h19; a = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(33, 5, 1'b0, "ignore_start");
        chk("ignore_start hi", 64'(hi), 64'd0);
        chk("ignore_start lo", 64'(lo), 64'd6);
        $display("op ignore_start -> hi=%08h lo=%08h", hi, lo);

        // Back-to-back: Start during the Done cycle
        alu_op = 2'b10; funct = 6'h1b; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b done_drops", 64'(done), 64'd0);
        wait_done(33, 0, 1'b0, "b2b");
        chk("b2b hi", 64'(hi), 64'd2);
        chk("b2b lo", 64'(lo), 64'd14);
        $display("op b2b divu 100/7 -> hi=%08h lo=%08h", hi, lo);
        mdl_hi = 32'd2; mdl_lo = 32'd14;
        @(negedge clk);

        // Randomized ops against the model
        for (int i = 0; i < 20; i++) begin
            f = 6'h18 + 6'($urandom_range(0, 3));
            av = $urandom;
            bv = $urandom;
            case ($urandom_range(0, 7))
                0: bv = 32'd0;
                1: begin av = 32'h80000000; bv = 32'hFFFFFFFF; end
                2: begin av = 32'($urandom_range(0, 255)); bv = 32'($urandom_range(1, 15)); end
                default: ;
            endcase
            ref_op(f, av, bv, mdl_hi, mdl_lo, eh, el, ed);
            run_op(f, av, bv, eh, el, ed, "rand");
        end

        // Asynchronous reset in the middle of a mult
        start_op(6'h18, 32'h12345, 32'h777);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset hi", 64'(hi), 64'd0);
        chk("midreset lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        chk("midreset no_done", 64'(seen), 64'd0);
        $display("op midreset -> busy=%0d hi=%08h lo=%08h", busy, hi, lo);
        mdl_hi = 32'd0; mdl_lo = 32'd0;
        run_op(6'h19, 32'd4, 32'd5, 32'd0, 32'd20, 1'b0, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_control_seq.md
# alu_control_seq

Parametrised successor to the combinational ALU control decoder for the multicycle MIPS core. It keeps combinational ALUOp/Funct → ALU-select decoding and gates Break so it fires only for R-type opcodes. It adds an iterative multiply/divide sequencer with a Start/Busy/Done handshake and architectural Hi/Lo registers. The block sits between the main control FSM (ALUOp, Start) and the datapath (operands A/B, ALU, Hi/Lo read mux).

## Interface
- W, 32: operand and Hi/Lo width (≥ 4).
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- ALUOp  in  2  from control FSM: 00 add, 01 sub, 10 R-type (use Funct), 11 and.
- Funct  in  6  instruction bits [5:0].
- Start  in  1  sampled at a Clk edge; launches mult/div when accepted.
- A  in  W  rs operand (dividend / multiplicand).
- B  in  W  rt operand (divisor / multiplier).
- AluSel  out  3  ALU op: 001 add, 010 sub, 011 and, 110 xor, 111 slt.
- Break  out  1  high iff ALUOp=10 and Funct=0x0d.
- Busy  out  1  sequencer running; the control FSM must stall.
- Done  out  1  one-cycle completion pulse.
- DivZero  out  1  valid only with Done; the completed divide had B=0.
- Hi  out  W  Hi register.
- Lo  out  W  Lo register.

## Operation
- AluSel decode is purely combinational and independent of Busy:
  - ALUOp 00 → 001.
  - ALUOp 01 → 010.
  - ALUOp 11 → 011.
  - ALUOp 10 with Funct 0x20/0x21 → 001, 0x22/0x23 → 010, 0x24 → 011, 0x26 → 110, 0x2a → 111.
  - Any other Funct → 001.
- Sequenced ops (ALUOp=10): 0x18 mult, 0x19 multu, 0x1a div, 0x1b divu.
- 0x10 mfhi and 0x12 mflo need no sequencing; the datapath reads Hi/Lo directly.
- Start is accepted only when all hold: Start=1, Busy=0, ALUOp=10, Funct is a sequenced op. Otherwise Start is ignored and state is unchanged.
- On acceptance the block latches the op, |A|, |B| (or the raw values for unsigned ops) and the result-sign flags.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
  - IDLE → MUL (mult/multu accepted).
  - IDLE → DIV (div/divu accepted, B≠0).
  - IDLE → DONE with DivZero (div/divu accepted, B=0).
  - DONE also accepts Start, with the same transitions as IDLE.
  - DONE → IDLE when no Start is accepted.
  - MUL/DIV → FIX after W iterations.
  - FIX → DONE.
- MUL: shift-add, one multiplier bit per cycle, 2W-bit accumulator.
- DIV: restoring division, one quotient bit per cycle; Lo = quotient, Hi = remainder.
- FIX performs sign correction and writes Hi/Lo.
  - mult: 2W-bit product negated if the signs of A and B differ.
  - div: quotient negated if the signs differ; remainder takes the sign of A.
  - Overflow case div(-2^(W-1), -1) gives Lo = 2^(W-1), Hi = 0. No trap.
- Divide by zero: Hi/Lo unchanged, DivZero=1 during Done.
- Hi/Lo change only at the FIX edge (or on reset).
- Reset_n low clears immediately, regardless of Clk:
  - state → IDLE, counter → 0.
  - Hi, Lo, Busy, Done, DivZero → 0.
  - An in-flight operation is discarded and produces no Done.
- Reset values: Hi=0, Lo=0, Busy=0, Done=0, DivZero=0. AluSel and Break follow their inputs.

## Timing
- Start is accepted at edge E.
- Normal op:
  - Busy=1 from E until edge E+W+1, i.e. during the W cycles in MUL/DIV plus the FIX cycle.
  - Hi/Lo are written at edge E+W+1.
  - Done=1 for exactly the cycle following E+W+1; Busy=0 in that cycle.
  - Latency is W+1 cycles from the accepting edge to Done.
- Divide by zero: Done=1 and DivZero=1 in the cycle following E; Busy never asserts.
- Start during the Done cycle is accepted, giving back-to-back ops with no bubble.
- Start while Busy=1 is ignored, and A/B changes have no effect on the running op.
- AluSel and Break settle combinationally in the same cycle as their inputs.

## Test plan
- Decode sweep:
  - ALUOp=10, Funct 0x20/0x22/0x24/0x26/0x2a → AluSel 001/010/011/110/111.
  - ALUOp=01 with any Funct → 010.
  - Break=1 only for ALUOp=10, Funct=0x0d; ALUOp=00, Funct=0x0d → Break=0.
- Multiply, W=32:
  - mult, A=0xFFFFFFFF, B=3 → Done 33 cycles after E; Hi=0xFFFFFFFF, Lo=0xFFFFFFFD.
  - multu, same operands → Hi=0x00000002, Lo=0xFFFFFFFD.
- Divide:
  - div, A=0xFFFFFFF9 (-7), B=2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
  - divu, A=7, B=2 → Lo=3, Hi=1.
  - div, A=0x80000000, B=0xFFFFFFFF → Lo=0x80000000, Hi=0.
- Divide by zero: prior Hi=0x11, Lo=0x22; div, A=5, B=0 → Done and DivZero high one cycle after E; Hi=0x11, Lo=0x22; Busy stays 0.
- Handshake:
  - Start a multu of 2×3; re-pulse Start at E+5 with A=9 → ignored, result Lo=6, Hi=0.
  - Start divu at the Done cycle → accepted; second Done 33 cycles later.
- Reset mid-op: Reset_n low at E+10 of a mult → Busy, Hi, Lo go 0 immediately; no Done; a following multu 4×5 gives Lo=20.
